// File: rtl/mpt_tlb.sv
// Single-outstanding MPT permission cache: fully-associative per-page R/W/X lookup,
// one walker request on a miss, fill on a successful walk, one-cycle response pulse.
module mpt_tlb #(
  parameter int ADDR_LEN   = 56,
  parameter int ENTRIES    = 4,
  parameter int PAGE_SHIFT = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_LEN-1:0] req_paddr_i,
  input  logic [1:0]          req_access_i,
  output logic                rsp_valid_o,
  output logic                rsp_allow_o,
  output logic                rsp_fault_o,
  output logic                rsp_hit_o,
  output logic                ptw_enable_o,
  output logic                ptw_addr_valid_o,
  output logic [ADDR_LEN-1:0] ptw_paddr_o,
  input  logic                ptw_valid_i,
  input  logic [63:0]         ptw_entry_i,
  input  logic                ptw_page_fault_i,
  input  logic                ptw_format_err_i
);

  localparam int TAG_W = ADDR_LEN - PAGE_SHIFT;
  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WALK_REQ  = 3'd2;
  localparam logic [2:0] S_WALK_WAIT = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]          state_q;
  logic [ADDR_LEN-1:0] paddr_q;
  logic [1:0]          access_q;
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q  [ENTRIES];
  logic [2:0]          perm_q [ENTRIES];
  logic [IDX_W-1:0]    rr_q;
  logic                allow_q, fault_q, hit_q;

  logic                hit_any;
  logic [2:0]          hit_perm;
  logic [IDX_W-1:0]    victim;
  logic                use_rr;
  logic                walk_fault, walk_done, do_fill;
  logic                unused_entry_bits;

  // Access 11 is reserved and never permitted.
  function automatic logic perm_sel(input logic [2:0] perm, input logic [1:0] acc);
    case (acc)
      2'b00:   perm_sel = perm[0];
      2'b01:   perm_sel = perm[1];
      2'b10:   perm_sel = perm[2];
      default: perm_sel = 1'b0;
    endcase
  endfunction

  always_comb begin
    hit_any  = 1'b0;
    hit_perm = 3'b000;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == paddr_q[ADDR_LEN-1:PAGE_SHIFT]) begin
        hit_any  = 1'b1;
        hit_perm = perm_q[i];
      end
    end
  end

  // Descending scan leaves the lowest-index free slot; fall back to round-robin.
  always_comb begin
    victim = rr_q;
    use_rr = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim = IDX_W'(i);
        use_rr = 1'b0;
      end
    end
  end

  assign walk_fault = ptw_page_fault_i | ptw_format_err_i;
  assign walk_done  = walk_fault | ptw_valid_i;
  assign do_fill    = (state_q == S_WALK_WAIT) && ptw_valid_i && !walk_fault && !flush_i;

  assign unused_entry_bits = ^ptw_entry_i[63:3];

  assign req_ready_o      = (state_q == S_IDLE) && !flush_i && !rst_i;
  assign rsp_valid_o      = (state_q == S_RESP);
  assign rsp_allow_o      = rsp_valid_o & allow_q;
  assign rsp_fault_o      = rsp_valid_o & fault_q;
  assign rsp_hit_o        = rsp_valid_o & hit_q;
  assign ptw_enable_o     = (state_q == S_WALK_REQ);
  assign ptw_addr_valid_o = (state_q == S_WALK_REQ);
  assign ptw_paddr_o      = paddr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      access_q <= 2'b00;
      valid_q  <= '0;
      rr_q     <= '0;
      allow_q  <= 1'b0;
      fault_q  <= 1'b0;
      hit_q    <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        perm_q[i] <= 3'b000;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            paddr_q  <= req_paddr_i;
            access_q <= req_access_i;
            state_q  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_any) begin
            allow_q <= perm_sel(hit_perm, access_q);
            fault_q <= 1'b0;
            hit_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            state_q <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: state_q <= S_WALK_WAIT;
        S_WALK_WAIT: begin
          if (walk_done) begin
            allow_q <= !walk_fault && perm_sel(ptw_entry_i[2:0], access_q);
            fault_q <= walk_fault;
            hit_q   <= 1'b0;
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (do_fill) begin
        valid_q[victim] <= 1'b1;
        tag_q[victim]   <= paddr_q[ADDR_LEN-1:PAGE_SHIFT];
        perm_q[victim]  <= ptw_entry_i[2:0];
        if (use_rr) rr_q <= rr_q + 1'b1;
      end

      // Flush wins over any same-cycle fill bookkeeping.
      if (flush_i) begin
        valid_q <= '0;
        rr_q    <= '0;
      end
    end
  end

endmodule

// File: doc/mpt_tlb.md
# mpt_tlb

Single-outstanding MPT permission cache in front of the MPT walker. It accepts physical-address access checks from the core and looks them up in a small fully-associative cache of per-page R/W/X permissions. On a hit it answers locally. On a miss it launches one walk on the walker's control port and answers from the walk result. A successful walk fills the cache; a faulting walk does not.

## Interface
Parameters:
- ADDR_LEN, 56, physical address width
- ENTRIES, 4, cache entries (power of two, ≥2)
- PAGE_SHIFT, 12, page offset bits; tag = paddr[ADDR_LEN-1:PAGE_SHIFT]

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- flush_i  in  1  invalidate all entries
- req_valid_i  in  1  check request
- req_ready_o  out  1  request accepted when valid&ready
- req_paddr_i  in  ADDR_LEN  address to check
- req_access_i  in  2  00 read, 01 write, 10 execute, 11 reserved
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_allow_o  out  1  access permitted
- rsp_fault_o  out  1  walk reported page or format fault
- rsp_hit_o  out  1  answered from cache
- ptw_enable_o  out  1  walk enable, one-cycle pulse
- ptw_addr_valid_o  out  1  walk address valid, same pulse
- ptw_paddr_o  out  ADDR_LEN  walk address (latched request)
- ptw_valid_i  in  1  walk done, entry valid
- ptw_entry_i  in  64  walk entry; bit0 R, bit1 W, bit2 X
- ptw_page_fault_i  in  1  walk access fault
- ptw_format_err_i  in  1  walk format fault (format_error nonzero)

## Operation
- Entry state: valid bit, tag, R/W/X.
- FSM states: IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESP.
- IDLE
  - req_ready_o = !flush_i.
  - On accept, latch paddr and access, then go to LOOKUP.
- LOOKUP
  - Compare the latched tag against all valid entries.
  - Hit: go to RESP with allow = perm[access] and hit = 1.
  - Miss: go to WALK_REQ.
- WALK_REQ
  - Assert ptw_enable_o and ptw_addr_valid_o for exactly one cycle with ptw_paddr_o = latched paddr.
  - Then go to WALK_WAIT.
- WALK_WAIT
  - Wait for ptw_valid_i, ptw_page_fault_i or ptw_format_err_i.
  - Any fault input high: allow = 0, fault = 1, no fill. Fault has priority over ptw_valid_i in the same cycle.
  - ptw_valid_i alone: fill the entry, allow = ptw_entry_i[access], fault = 0, hit = 0.
  - Then go to RESP.
- RESP
  - rsp_valid_o = 1 for one cycle; rsp_* hold their registered values during that cycle.
  - Return to IDLE.
- Permission mapping: read uses R, write uses W, execute uses X. Access 11 gives allow = 0 but is otherwise processed normally (lookup, walk, fill).
- Fill victim selection:
  - The lowest-index invalid entry, if any.
  - Otherwise the entry at the round-robin pointer. The pointer increments modulo ENTRIES on each fill that used it.
- Flush
  - All valid bits clear on the next edge, in any state.
  - In WALK_WAIT, the walk still completes and responds, but a fill in the same cycle as flush_i is suppressed.
  - A flush asserted earlier during the walk does not suppress the later fill.
  - The round-robin pointer resets to 0 on flush.
- Single outstanding request: no new request is accepted until RESP completes.

## Timing
- Reset values:
  - State IDLE, all entries invalid, pointer 0.
  - All outputs 0 except req_ready_o. req_ready_o reads 1 in IDLE once rst_i is low, subject to flush_i.
- Hit latency: accept at edge N; LOOKUP in cycle N+1; rsp_valid_o high in cycle N+2.
- Miss: ptw pulse in cycle N+2. rsp_valid_o is high in the cycle after the walker completion input is sampled. The fill is visible to a lookup starting in that RESP cycle's successor.
- rsp_* are don't-care when rsp_valid_o = 0 but are driven to 0.
- Reset mid-walk: the FSM returns to IDLE immediately. The walker is not notified; it is reset by the same system reset.
- Walker inputs outside WALK_WAIT are ignored.

## Test plan
- Reset, then read 0x1000 (walk returns entry 0x7): one ptw pulse, ptw_paddr_o = 0x1000, response allow = 1, hit = 0. Repeat read 0x1234: no walk, hit = 1, allow = 1, rsp_valid_o at accept + 2.
- Fill 0x2000 with entry 0x1 (R only), then write 0x2008: hit = 1, allow = 0, fault = 0. Execute: allow = 0. Access 11: allow = 0.
- Miss 0x3000 with ptw_page_fault_i (and ptw_valid_i in the same cycle): allow = 0, fault = 1. Re-request 0x3000 must walk again.
- Fill 5 distinct pages with ENTRIES = 4: the 5th fill replaces entry 0. The 1st page then misses; pages 2–5 hit.
- flush_i pulse after two fills: both pages miss. flush_i held in IDLE: req_ready_o = 0. Flush in the same cycle as ptw_valid_i: response is still produced, and the next request for that page walks again.
- Assert rst_i during WALK_WAIT: outputs go to 0 asynchronously, and the next request misses.
